adder16_arbiter: RTL and testbench
==================================

Name: adder16_arbiter

Overview:
Shares a single combinational adder16 instance between two requesters using valid/ready handshakes and round-robin (or fixed) priority. A 3-state FSM sequences each accepted operation: latch operands, capture sum and flags, hold the response until the owning requester accepts it. Sits between the two client datapaths and the shared 16-bit adder. It is the unit that schedules all adder use.

Parameters:
PRIO_FIXED, 0, 0 = round-robin between requesters; 1 = requester 0 always wins a tie
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 operands accepted this cycle
req0_x  in  16  requester 0 operand X
req0_y  in  16  requester 0 operand Y
req1_valid  in  1  requester 1 has operands
req1_ready  out  1  requester 1 operands accepted this cycle
req1_x  in  16  requester 1 operand X
req1_y  in  16  requester 1 operand Y
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp1_valid  out  1  result available for requester 1
rsp1_ready  in  1  requester 1 takes result
rsp_z  out  16  registered sum
rsp_flags  out  5  registered {S,ZR,CY,P,V}
busy  out  1  FSM not in IDLE
grant_id  out  1  requester owning current/last operation
op_count  out  CNT_W  completed operations (response handshakes), wraps

Behaviour:
- Internal adder16 instance, ports in order (X,Y,Z,S,ZR,CY,P,V): Z=X+Y mod 2^16; S=Z[15]; ZR=(Z==0); CY=carry out of bit 15; P=1 when Z has even number of ones; V=signed overflow (X15==Y15 and Z15!=X15).
- Reset (async, any state): FSM=IDLE, rsp_z=0, rsp_flags=0, rsp*_valid=0, busy=0, grant_id=0, op_count=0, rr pointer=0 (requester 0 preferred). In-flight operation discarded; no response issued.
- States: IDLE, EXEC, RESP.
- IDLE: winner = only valid requester; if both valid: pointer requester (PRIO_FIXED=1: requester 0). reqN_ready=1 combinationally only for winner, only in IDLE. On reqN_valid&reqN_ready: latch X,Y into operand regs, grant_id<=N, -> EXEC. No valid: stay.
- EXEC: exactly one cycle; adder output from latched operands captured into rsp_z/rsp_flags; -> RESP.
- RESP: rspN_valid=1 for N=grant_id only; other rsp valid=0. Stay until rspN_ready=1; then op_count+1 (wraps at 2^CNT_W), pointer<=~grant_id (round-robin mode), -> IDLE.
- Latency: accept edge at cycle T -> rsp valid from cycle T+2. Max throughput 1 op / 3 cycles.
- All req*_ready=0 outside IDLE; new requests wait (requesters hold valid and data stable until ready).
- rsp_z/rsp_flags hold last result after return to IDLE until next EXEC.
- rsp_ready on non-granted channel, or outside RESP, ignored.
- rspN_ready already high on entering RESP: handshake completes in first RESP cycle.
- Simultaneous req valid on both in IDLE: exactly one ready asserted; loser served next (round-robin).
- Requester dropping valid before grant: no effect, no op recorded.

Test Plan:
- Reset mid-EXEC with req0 8fff+8000 -> next cycle all outputs 0, busy=0, no rsp0_valid ever for that op, op_count=0.
- req0 X=8fff Y=8000, rsp0_ready=1 -> req0_ready in IDLE, rsp0_valid 2 cycles later, rsp_z=0fff, flags {S,ZR,CY,P,V}=0,0,1,1,1, op_count=1.
- req1 X=fffe Y=0002 -> rsp1_valid only, rsp_z=0000, flags 0,1,1,1,0; rsp0_valid stays 0.
- Both valid continuously, 4 ops, PRIO_FIXED=0 -> grants 0,1,0,1; aaaa+5555 gives rsp_z=ffff, flags 1,0,0,1,0; op_count=4.
- Both valid, PRIO_FIXED=1 -> requester 0 granted every time while valid; req1 granted only after req0_valid drops.
- Hold rsp0_ready=0 for 5 cycles in RESP -> rsp0_valid held, rsp_z stable, req*_ready=0, busy=1; release -> IDLE next cycle, op_count increments once.

Source files
------------

// File: rtl/adder16_arbiter.sv
// adder16_arbiter: shares one combinational 16-bit adder between two
// requesters. A three-state sequencer (IDLE -> EXEC -> RESP) accepts one
// operation at a time, captures the sum and status flags, and holds the
// response until the owning requester takes it. Arbitration is round-robin
// or fixed priority (requester 0 wins ties).

// Shared combinational adder: Z = X + Y with {S, ZR, CY, P, V} status.
module adder16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] z,
  output logic        s,
  output logic        zr,
  output logic        cy,
  output logic        p,
  output logic        v
);

  // Even parity: 1 when the word holds an even number of ones.
  function automatic logic even_parity(input logic [15:0] data);
    return ~(^data);
  endfunction

  logic [16:0] sum_s;
  logic        carry_in_msb_s;

  // Sum plus flags; overflow is carry into bit 15 differing from carry out.
  always_comb begin
    sum_s          = {1'b0, x} + {1'b0, y};
    z              = sum_s[15:0];
    cy             = sum_s[16];
    s              = sum_s[15];
    zr             = (sum_s[15:0] == 16'h0000);
    p              = even_parity(sum_s[15:0]);
    carry_in_msb_s = x[15] ^ y[15] ^ sum_s[15];
    v              = carry_in_msb_s ^ sum_s[16];
  end

endmodule

module adder16_arbiter #(
  parameter int          PRIO_FIXED = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_x,
  input  logic [15:0]      req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_x,
  input  logic [15:0]      req1_y,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [15:0]      rsp_z,
  output logic [4:0]       rsp_flags,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;

  logic [15:0]        op_x_r;
  logic [15:0]        op_y_r;
  logic [15:0]        rsp_z_r;
  logic [4:0]         rsp_flags_r;
  logic               grant_r;
  logic               rr_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               any_valid_s;
  logic               winner_s;
  logic               accept_s;
  logic               done_s;
  logic               rsp_take_s;
  logic               req0_ready_s;
  logic               req1_ready_s;
  logic               rsp0_valid_s;
  logic               rsp1_valid_s;

  logic [15:0]        add_z_s;
  logic               add_s_s;
  logic               add_zr_s;
  logic               add_cy_s;
  logic               add_p_s;
  logic               add_v_s;

  // The adder only ever sees the latched operands, so its result is stable
  // throughout EXEC regardless of what the requesters do.
  adder16 u_adder (
    .x  (op_x_r),
    .y  (op_y_r),
    .z  (add_z_s),
    .s  (add_s_s),
    .zr (add_zr_s),
    .cy (add_cy_s),
    .p  (add_p_s),
    .v  (add_v_s)
  );

  // Pick the winner among valid requesters; ties go to the preferred one.
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    winner_s    = 1'b0;
    if (req0_valid && req1_valid) begin
      if (PRIO_FIXED != 0) begin
        winner_s = 1'b0;
      end else begin
        winner_s = rr_ptr_r;
      end
    end else if (req1_valid) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Next-state and handshake decode for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    next_state_s = state_r;
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    rsp0_valid_s = 1'b0;
    rsp1_valid_s = 1'b0;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    rsp_take_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          if (winner_s) begin
            req1_ready_s = 1'b1;
          end else begin
            req0_ready_s = 1'b1;
          end
          accept_s     = 1'b1;
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        next_state_s = ST_RESP;
      end
      ST_RESP: begin
        if (grant_r) begin
          rsp1_valid_s = 1'b1;
          rsp_take_s   = rsp1_ready;
        end else begin
          rsp0_valid_s = 1'b1;
          rsp_take_s   = rsp0_ready;
        end
        if (rsp_take_s) begin
          done_s       = 1'b1;
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand latch and owner capture on the accepting handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_x_r  <= 16'h0000;
      op_y_r  <= 16'h0000;
      grant_r <= 1'b0;
    end else if (accept_s) begin
      if (winner_s) begin
        op_x_r <= req1_x;
        op_y_r <= req1_y;
      end else begin
        op_x_r <= req0_x;
        op_y_r <= req0_y;
      end
      grant_r <= winner_s;
    end
  end

  // Result capture in EXEC; the last result is held until the next EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_z_r     <= 16'h0000;
      rsp_flags_r <= 5'b00000;
    end else if (state_r == ST_EXEC) begin
      rsp_z_r     <= add_z_s;
      rsp_flags_r <= {add_s_s, add_zr_s, add_cy_s, add_p_s, add_v_s};
    end
  end

  // Completion bookkeeping: wrapping op counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= '0;
      rr_ptr_r <= 1'b0;
    end else if (done_s) begin
      count_r <= count_r + CNT_W'(1);
      if (PRIO_FIXED == 0) begin
        rr_ptr_r <= ~grant_r;
      end
    end
  end

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign rsp0_valid = rsp0_valid_s;
  assign rsp1_valid = rsp1_valid_s;
  assign rsp_z      = rsp_z_r;
  assign rsp_flags  = rsp_flags_r;
  assign busy       = (state_r != ST_IDLE);
  assign grant_id   = grant_r;
  assign op_count   = count_r;

endmodule

// File: tb/tb_adder16_arbiter.sv
// Scoreboard bench for adder16_arbiter: a round-robin instance and a
// fixed-priority instance run side by side. A transaction-level model
// predicts handshakes and pushes expected responses; a monitor pops them
// when a response handshake occurs.
module tb_adder16_arbiter;

  typedef struct packed {
    logic        id;
    logic [15:0] z;
    logic [4:0]  flags;
    logic [15:0] seq;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2][2];
  logic [15:0] req_x     [2][2];
  logic [15:0] req_y     [2][2];
  logic        rsp_ready [2][2];
  logic        req_ready [2][2];
  logic        rsp_valid [2][2];
  logic [15:0] rsp_z     [2];
  logic [4:0]  rsp_flags [2];
  logic        busy      [2];
  logic        grant_id  [2];
  logic [15:0] op_count  [2];

  int total = 0;
  int bad   = 0;

  item_t sb0[$];
  item_t sb1[$];

  // Model state per instance (0 = round-robin, 1 = fixed priority).
  bit          m_idle  [2];
  int          m_wait  [2];
  logic        m_owner [2];
  logic        m_pref  [2];
  logic [15:0] m_seq   [2];
  item_t       m_cur   [2];
  bit          acc     [2][2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    adder16_arbiter #(.PRIO_FIXED(g), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req_valid[g][0]),
      .req0_ready (req_ready[g][0]),
      .req0_x     (req_x[g][0]),
      .req0_y     (req_y[g][0]),
      .req1_valid (req_valid[g][1]),
      .req1_ready (req_ready[g][1]),
      .req1_x     (req_x[g][1]),
      .req1_y     (req_y[g][1]),
      .rsp0_valid (rsp_valid[g][0]),
      .rsp0_ready (rsp_ready[g][0]),
      .rsp1_valid (rsp_valid[g][1]),
      .rsp1_ready (rsp_ready[g][1]),
      .rsp_z      (rsp_z[g]),
      .rsp_flags  (rsp_flags[g]),
      .busy       (busy[g]),
      .grant_id   (grant_id[g]),
      .op_count   (op_count[g])
    );
  end

  task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL dut%0d %s: got %h expected %h (t=%0t)", d, nm, act, exp, $time);
    end
  endtask

  // Reference sum: plain integer arithmetic, flags from their definitions.
  function automatic logic [20:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    int unsigned usum;
    int          ssum;
    logic [15:0] z;
    logic        s, zr, cy, p, v;
    usum = 32'(x) + 32'(y);
    ssum = int'($signed(x)) + int'($signed(y));
    z    = usum[15:0];
    s    = z[15];
    zr   = (z == 16'h0000);
    cy   = (usum >= 32'd65536);
    p    = (($countones(z) % 2) == 0);
    v    = (ssum > 32767) || (ssum < -32768);
    return {s, zr, cy, p, v, z};
  endfunction

  // Evaluate the model for one cycle (called mid-cycle), check, advance.
  task automatic model_eval(input int d);
    logic        w;
    logic [20:0] r;
    item_t       it;
    acc[d][0] = 1'b0;
    acc[d][1] = 1'b0;
    if (rst) begin
      chk(d, "rst_busy", busy[d], 0);
      chk(d, "rst_rsp0_valid", rsp_valid[d][0], 0);
      chk(d, "rst_rsp1_valid", rsp_valid[d][1], 0);
      chk(d, "rst_rsp_z", rsp_z[d], 0);
      chk(d, "rst_flags", rsp_flags[d], 0);
      chk(d, "rst_grant", grant_id[d], 0);
      chk(d, "rst_op_count", op_count[d], 0);
      m_idle[d] = 1'b1;
      m_wait[d] = 0;
      m_pref[d] = 1'b0;
      m_seq[d]  = 16'h0000;
      if (d == 0) sb0.delete(); else sb1.delete();
    end else begin
      chk(d, "op_count", op_count[d], m_seq[d]);
      chk(d, "busy", busy[d], !m_idle[d]);
      if (m_idle[d]) begin
        if (req_valid[d][0] && req_valid[d][1]) w = (d == 1) ? 1'b0 : m_pref[d];
        else w = req_valid[d][1];
        chk(d, "req0_ready", req_ready[d][0], req_valid[d][0] && (w == 1'b0));
        chk(d, "req1_ready", req_ready[d][1], req_valid[d][1] && (w == 1'b1));
        chk(d, "idle_rsp0_valid", rsp_valid[d][0], 0);
        chk(d, "idle_rsp1_valid", rsp_valid[d][1], 0);
        if (req_valid[d][0] || req_valid[d][1]) begin
          acc[d][w] = 1'b1;
          r         = ref_add(req_x[d][w], req_y[d][w]);
          it.id     = w;
          it.z      = r[15:0];
          it.flags  = r[20:16];
          it.seq    = m_seq[d];
          if (d == 0) sb0.push_back(it); else sb1.push_back(it);
          m_idle[d]  = 1'b0;
          m_wait[d]  = 1;
          m_owner[d] = w;
          m_cur[d]   = it;
        end
      end else if (m_wait[d] > 0) begin
        chk(d, "exec_req0_ready", req_ready[d][0], 0);
        chk(d, "exec_req1_ready", req_ready[d][1], 0);
        chk(d, "exec_rsp0_valid", rsp_valid[d][0], 0);
        chk(d, "exec_rsp1_valid", rsp_valid[d][1], 0);
        m_wait[d]--;
      end else begin
        chk(d, "resp_req0_ready", req_ready[d][0], 0);
        chk(d, "resp_req1_ready", req_ready[d][1], 0);
        chk(d, "resp_owner_valid", rsp_valid[d][m_owner[d]], 1);
        chk(d, "resp_other_valid", rsp_valid[d][!m_owner[d]], 0);
        chk(d, "resp_z_hold", rsp_z[d], m_cur[d].z);
        chk(d, "resp_flags_hold", rsp_flags[d], m_cur[d].flags);
        chk(d, "resp_grant_id", grant_id[d], m_owner[d]);
        if (rsp_ready[d][m_owner[d]]) begin
          m_idle[d] = 1'b1;
          m_seq[d]  = m_seq[d] + 16'd1;
          m_pref[d] = !m_owner[d];
        end
      end
    end
  endtask

  // Monitor: on every response handshake, pop and compare the expected item.
  always @(negedge clk) begin
    item_t it;
    if (rst !== 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++) begin
          if (rsp_valid[d][r] === 1'b1 && rsp_ready[d][r] === 1'b1) begin
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
              chk(d, "unexpected_rsp", 32'(r) + 32'd1, 0);
            end else begin
              if (d == 0) it = sb0.pop_front(); else it = sb1.pop_front();
              chk(d, "mon_id", r, it.id);
              chk(d, "mon_z", rsp_z[d], it.z);
              chk(d, "mon_flags", rsp_flags[d], it.flags);
              chk(d, "mon_op_count", op_count[d], it.seq);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    model_eval(0);
    model_eval(1);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 2; r++)
        if (acc[d][r]) req_valid[d][r] = 1'b0;
  endtask

  task automatic set_req(input int r, input logic v, input logic [15:0] x, input logic [15:0] y);
    for (int d = 0; d < 2; d++) begin
      req_valid[d][r] = v;
      req_x[d][r]     = x;
      req_y[d][r]     = y;
    end
  endtask

  task automatic set_rsp_ready(input logic v0, input logic v1);
    for (int d = 0; d < 2; d++) begin
      rsp_ready[d][0] = v0;
      rsp_ready[d][1] = v1;
    end
  endtask

  function automatic logic [15:0] rand_operand();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hffff;
      2:       return 16'h8000;
      3:       return 16'h7fff;
      default: return v;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 16'h0000, 16'h0000);
    set_req(1, 1'b0, 16'h0000, 16'h0000);
    set_rsp_ready(1'b1, 1'b1);
    for (int d = 0; d < 2; d++) begin
      m_idle[d] = 1'b1; m_wait[d] = 0; m_owner[d] = 1'b0;
      m_pref[d] = 1'b0; m_seq[d] = 16'h0000; m_cur[d] = '0;
      acc[d][0] = 1'b0; acc[d][1] = 1'b0;
    end
    #1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single op on requester 0, then requester 1.
    set_req(0, 1'b1, 16'h8fff, 16'h8000);
    repeat (4) step();
    set_req(1, 1'b1, 16'hfffe, 16'h0002);
    repeat (4) step();

    // Both requesters continuously valid.
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!req_valid[d][0]) begin req_valid[d][0] = 1'b1; req_x[d][0] = 16'haaaa; req_y[d][0] = 16'h5555; end
        if (!req_valid[d][1]) begin req_valid[d][1] = 1'b1; req_x[d][1] = 16'h1234; req_y[d][1] = 16'h4321; end
      end
      step();
    end
    // Requester 0 stops; requester 1 (still waiting on the fixed instance) gets served.
    for (int d = 0; d < 2; d++) req_valid[d][0] = 1'b0;
    repeat (8) step();
    set_req(1, 1'b0, 16'h0000, 16'h0000);
    repeat (4) step();

    // Response back-pressure while a new request waits.
    set_rsp_ready(1'b0, 1'b0);
    set_req(0, 1'b1, 16'h1111, 16'h2222);
    step();
    set_req(1, 1'b1, 16'h0f0f, 16'hf0f0);
    repeat (7) step();
    set_rsp_ready(1'b1, 1'b1);
    set_req(1, 1'b0, 16'h0000, 16'h0000);
    repeat (6) step();

    // Reset while an operation is in EXEC: it must vanish without a response.
    set_req(0, 1'b1, 16'h8fff, 16'h8000);
    step();
    rst = 1'b1;
    set_req(0, 1'b0, 16'h0000, 16'h0000);
    step();
    rst = 1'b0;
    repeat (5) step();

    // Randomized traffic with random response back-pressure and early drops.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++) begin
          if (!req_valid[d][r]) begin
            if ($urandom_range(0, 1) == 1) begin
              req_valid[d][r] = 1'b1;
              req_x[d][r]     = rand_operand();
              req_y[d][r]     = rand_operand();
            end
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid[d][r] = 1'b0;
          end
          rsp_ready[d][r] = ($urandom_range(0, 3) != 0);
        end
      end
      step();
    end

    // Drain and confirm every expected response was delivered.
    set_req(0, 1'b0, 16'h0000, 16'h0000);
    set_req(1, 1'b0, 16'h0000, 16'h0000);
    set_rsp_ready(1'b1, 1'b1);
    repeat (6) step();
    chk(0, "drain_queue", 32'(sb0.size()), 0);
    chk(1, "drain_queue", 32'(sb1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
